// File: rtl/aes_pkg.sv
// Shared AES types, round constants and the forward S-box table.
// Used by the key schedule and by the aesMain datapath stages.
package aes_pkg;

   typedef logic [0:7]       byte_t;
   typedef byte_t [0:3]      word_t;
   typedef byte_t [0:3][0:3] state_t;

   localparam int AES128_NR = 10;

   localparam byte_t RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam byte_t SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic word_t sub_word(input word_t w);
      word_t s;
      for (int i = 0; i < 4; i++) begin
         s[i] = SBOX[w[i]];
      end
      return s;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
// Shared between the key schedule (SubWord) and the SubBytes stage.
module aes_sbox
   import aes_pkg::*;
(
   input  byte_t a_i,
   output byte_t y_o
);

   assign y_o = SBOX[a_i];

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES-128 key schedule: accepts one cipher key and streams round keys 0..10.
// Optional macro AES_KEY_STORE_EN adds an 11-entry round-key bank with a combinational read port.
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int NR = AES128_NR
) (
   input  logic       clk,
   input  logic       rst,
   input  state_t     key_in,
   input  logic       key_valid,
   output logic       key_ready,
   output state_t     rk_out,
   output logic [3:0] rk_round,
   output logic       rk_valid,
   input  logic       rk_ready,
   output logic       rk_last
`ifdef AES_KEY_STORE_EN
   ,
   input  logic [3:0] rd_idx,
   output state_t     rd_key
`endif
);

   if (NR != AES128_NR) begin : g_bad_nr
      $error("aes_key_expand: NR must be 10 for AES-128");
   end

   localparam logic [3:0] LAST_RND = 4'(NR);
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_EMIT  = 1'b1;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // the producer holds its payload stable while valid is high and ready is low.

   logic [0:0] state_q, state_d;
   state_t     rk_q, rk_d, rk_nxt;
   logic [3:0] rnd_q, rnd_d, rnd_nxt;
   logic       valid_q, valid_d;
   logic       last_q, last_d;
   logic       accept, beat;
   byte_t      rcon_b;
   word_t      rot_w, sub_w, t_w;

   assign key_ready = (state_q == ST_IDLE);
   assign accept    = key_valid && key_ready;
   assign beat      = valid_q && rk_ready;
   assign rnd_nxt   = rnd_q + 4'd1;

   // Rcon for the round being produced; zero once the schedule is exhausted.
   always_comb begin
      rcon_b = '0;
      for (int i = 1; i <= 10; i++) begin
         if (rnd_nxt == 4'(i)) begin
            rcon_b = RCON[i];
         end
      end
   end

   always_comb begin
      rot_w = '0;
      for (int r = 0; r < 4; r++) begin
         rot_w[r] = rk_q[(r + 1) % 4][3];
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .a_i (rot_w[g]),
         .y_o (sub_w[g])
      );
   end

   always_comb begin
      t_w    = sub_w;
      t_w[0] = sub_w[0] ^ rcon_b;
   end

   // Each new column is the old column XOR the previous new column, seeded with t.
   always_comb begin : p_next
      word_t acc;
      acc    = t_w;
      rk_nxt = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc[r]       = acc[r] ^ rk_q[r][c];
            rk_nxt[r][c] = acc[r];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rk_d    = rk_q;
      rnd_d   = rnd_q;
      valid_d = valid_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rk_d    = key_in;
               rnd_d   = '0;
               valid_d = 1'b1;
               last_d  = 1'b0;
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (beat) begin
               if (rnd_q == LAST_RND) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  rk_d    = rk_nxt;
                  rnd_d   = rnd_nxt;
                  last_d  = (rnd_nxt == LAST_RND);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rk_q    <= '0;
         rnd_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rk_q    <= rk_d;
         rnd_q   <= rnd_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign rk_out   = rk_q;
   assign rk_round = rnd_q;
   assign rk_valid = valid_q;
   assign rk_last  = last_q;

`ifdef AES_KEY_STORE_EN
   state_t     bank_q [0:10];
   logic       bank_we;
   logic [3:0] bank_idx;

   // Each entry is written together with the rk register load that produces its round.
   assign bank_we  = (state_q == ST_IDLE && accept) ||
                     (state_q == ST_EMIT && beat && rnd_q != LAST_RND);
   assign bank_idx = (state_q == ST_IDLE) ? 4'd0 : rnd_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= 10; i++) begin
            bank_q[i] <= '0;
         end
      end else if (bank_we) begin
         bank_q[bank_idx] <= rk_d;
      end
   end

   always_comb begin
      rd_key = '0;
      for (int i = 0; i <= 10; i++) begin
         if (rd_idx == 4'(i)) begin
            rd_key = bank_q[i];
         end
      end
   end
`endif

endmodule
